// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter
// Shares the single USB FIFO byte-write port between up to four requesters.
// Each granted requester supplies one 16-bit word (status byte, data byte),
// emitted as two strobed bytes, high byte first, never interleaved.
// Optional build macro: USB_ARB_PRIORITY0_EN gives requester 0 strict
// priority; the remaining requesters round-robin among themselves.
// Handshake: a requester holds i_Req/i_Word until it sees its o_Grant pulse;
// a byte is written to the FIFO in any cycle where o_dataReady is high, and
// a strobe is only issued when i_usbReady was high at the preceding edge.
module usb_tx_arbiter #(
    parameter int N_REQ       = 2,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic [N_REQ-1:0]     i_Req,
    input  logic [16*N_REQ-1:0]  i_Word,
    output logic [N_REQ-1:0]     o_Grant,
    input  logic                 i_usbReady,
    output logic                 o_dataReady,
    output logic [7:0]           o_data,
    output logic                 o_busy,
    output logic                 o_stall,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        GAP     = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [2:0] NREQ3   = 3'(N_REQ);
    localparam logic [1:0] PTR_RST = 2'(N_REQ - 1);
    localparam logic [9:0] LIMIT   = 10'(STALL_LIMIT);

    state_t             state, stateNext;
    logic [15:0]        word, wordNext;
    logic [1:0]         ptr, ptrNext;
    logic [9:0]         stallCnt, stallCntNext;
    logic [N_REQ-1:0]   grantNext;
    logic               dataReadyNext;
    logic [7:0]         dataNext;
    logic               stallNext;

    logic [3:0]         reqExt;
    logic [2:0]         probe;
    logic               eligible;
    logic               found;
    logic [1:0]         win;
    logic [15:0]        selWord;
    logic [N_REQ-1:0]   selGrant;

    // Round-robin winner search starting one past the pointer
    always_comb begin
        reqExt   = '0;
        reqExt[N_REQ-1:0] = i_Req;
        probe    = '0;
        eligible = 1'b0;
        found    = 1'b0;
        win      = '0;
`ifdef USB_ARB_PRIORITY0_EN
        if (reqExt[0]) begin
            found = 1'b1;
            win   = 2'd0;
        end
`endif
        for (int off = 1; off <= N_REQ; off++) begin
            probe = {1'b0, ptr} + 3'(off);
            if (probe >= NREQ3) begin
                probe = probe - NREQ3;
            end
            eligible = reqExt[probe[1:0]];
`ifdef USB_ARB_PRIORITY0_EN
            if (probe == 3'd0) begin
                eligible = 1'b0;
            end
`endif
            if (!found && eligible) begin
                found = 1'b1;
                win   = probe[1:0];
            end
        end
    end

    // Word mux and one-hot grant for the selected requester
    always_comb begin
        selWord  = '0;
        selGrant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == 2'(k)) begin
                selWord = i_Word[16*k +: 16];
            end
            selGrant[k] = found && (win == 2'(k));
        end
    end

    // Next-state, output and stall-counter logic
    always_comb begin
        stateNext     = state;
        wordNext      = word;
        ptrNext       = ptr;
        stallCntNext  = stallCnt;
        grantNext     = '0;
        dataReadyNext = 1'b0;
        dataNext      = o_data;
        case (state)
            IDLE: begin
                if (found) begin
                    grantNext = selGrant;
                    wordNext  = selWord;
                    stateNext = WAIT_HI;
`ifdef USB_ARB_PRIORITY0_EN
                    if (win != 2'd0) begin
                        ptrNext = win;
                    end
`else
                    ptrNext = win;
`endif
                end
            end
            WAIT_HI: begin
                if (i_usbReady) begin
                    dataReadyNext = 1'b1;
                    dataNext      = word[15:8];
                    stallCntNext  = '0;
                    stateNext     = GAP;
                end else if (stallCnt < LIMIT) begin
                    stallCntNext = stallCnt + 10'd1;
                end
            end
            GAP: begin
                dataNext  = word[7:0];
                stateNext = WAIT_LO;
            end
            WAIT_LO: begin
                if (i_usbReady) begin
                    dataReadyNext = 1'b1;
                    stallCntNext  = '0;
                    stateNext     = IDLE;
                end else if (stallCnt < LIMIT) begin
                    stallCntNext = stallCnt + 10'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        stallNext = o_stall | (stallCntNext == LIMIT);
    end

    // Register state and all outputs; reset drops any partial word at once
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= IDLE;
            word        <= '0;
            ptr         <= PTR_RST;
            stallCnt    <= '0;
            o_Grant     <= '0;
            o_dataReady <= 1'b0;
            o_data      <= '0;
            o_stall     <= 1'b0;
        end else begin
            state       <= stateNext;
            word        <= wordNext;
            ptr         <= ptrNext;
            stallCnt    <= stallCntNext;
            o_Grant     <= grantNext;
            o_dataReady <= dataReadyNext;
            o_data      <= dataNext;
            o_stall     <= stallNext;
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_state = state;

endmodule
